// File: rtl/dimension_parser_pkg.sv
// Shared types and ASCII constants for the puzzle-input byte parsers.
package dimension_parser_pkg;

  localparam int unsigned DEFAULT_SIZE_WIDTH        = 8;
  localparam int unsigned DEFAULT_ERROR_COUNT_WIDTH = 16;

  typedef logic [DEFAULT_SIZE_WIDTH-1:0] size_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [1:0] {
    PARSE_LENGTH = 2'd0,
    PARSE_WIDTH  = 2'd1,
    PARSE_HEIGHT = 2'd2,
    SKIP_LINE    = 2'd3
  } parse_state_t;

  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: acc <= acc*10 + digit, with overflow flagged on the full-width result.
module decimal_accumulator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit_value,
  output logic [WIDTH-1:0] acc,
  output logic             digit_seen,
  output logic             overflow_c
);

  localparam int unsigned PROD_WIDTH = WIDTH + 4;

  logic [PROD_WIDTH-1:0] product_c;

  // acc*10+9 always fits in WIDTH+4 bits, so the upper bits expose overflow exactly.
  assign product_c  = PROD_WIDTH'(acc) * PROD_WIDTH'(10) + PROD_WIDTH'(digit_value);
  assign overflow_c = digit_valid && (product_c[PROD_WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      digit_seen <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      digit_seen <= 1'b0;
    end else if (digit_valid) begin
      acc        <= product_c[WIDTH-1:0];
      digit_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/dimension_parser.sv
// Parses "LxWxH\n" ASCII lines into (length, width, height) tuples; drops and counts bad lines.
module dimension_parser
  import dimension_parser_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH        = DEFAULT_SIZE_WIDTH,
  parameter int unsigned ERROR_COUNT_WIDTH = DEFAULT_ERROR_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inbound_valid,
  input  logic [7:0]                   inbound_data,
  output logic                         size_valid,
  output logic [SIZE_WIDTH-1:0]        length,
  output logic [SIZE_WIDTH-1:0]        width,
  output logic [SIZE_WIDTH-1:0]        height,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count
);

  parse_state_t state, next_state;

  logic                  is_digit, is_x, is_lf, is_cr, in_parse;
  logic [3:0]            digit_value;
  logic [SIZE_WIDTH-1:0] acc;
  logic                  digit_seen, overflow_c;
  logic                  acc_clear, acc_digit, latch_len, latch_wid, commit, err_inc;
  logic [SIZE_WIDTH-1:0] len_q, wid_q;

  assign is_digit    = is_ascii_digit(inbound_data);
  assign is_x        = (inbound_data == ASCII_X);
  assign is_lf       = (inbound_data == ASCII_LF);
  assign is_cr       = (inbound_data == ASCII_CR);
  assign in_parse    = (state != SKIP_LINE);
  assign digit_value = 4'(inbound_data - ASCII_ZERO);

  decimal_accumulator #(.WIDTH(SIZE_WIDTH)) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .digit_valid (acc_digit),
    .digit_value (digit_value),
    .acc         (acc),
    .digit_seen  (digit_seen),
    .overflow_c  (overflow_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PARSE_LENGTH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (inbound_valid) begin
      if (state == SKIP_LINE) begin
        if (is_lf) next_state = PARSE_LENGTH;
      end else if (is_lf) begin
        next_state = PARSE_LENGTH;
      end else if (is_digit) begin
        if (overflow_c) next_state = SKIP_LINE;
      end else if (is_x) begin
        if (digit_seen && state == PARSE_LENGTH)     next_state = PARSE_WIDTH;
        else if (digit_seen && state == PARSE_WIDTH) next_state = PARSE_HEIGHT;
        else                                         next_state = SKIP_LINE;
      end else if (!is_cr) begin
        next_state = SKIP_LINE;
      end
    end
  end

  // Per-byte datapath controls; an empty line in PARSE_LENGTH raises no error.
  always_comb begin
    acc_digit = 1'b0;
    latch_len = 1'b0;
    latch_wid = 1'b0;
    commit    = 1'b0;
    err_inc   = 1'b0;
    if (inbound_valid) begin
      acc_digit = in_parse && is_digit;
      latch_len = (state == PARSE_LENGTH) && is_x && digit_seen;
      latch_wid = (state == PARSE_WIDTH) && is_x && digit_seen;
      commit    = (state == PARSE_HEIGHT) && is_lf && digit_seen;
      err_inc   = is_lf && ((state == SKIP_LINE) ||
                            (state == PARSE_LENGTH && digit_seen) ||
                            (state == PARSE_WIDTH) ||
                            (state == PARSE_HEIGHT && !digit_seen));
    end
    acc_clear = latch_len || latch_wid || (inbound_valid && is_lf);
  end

  // Fields are staged internally so the outputs only move together with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      wid_q       <= '0;
      length      <= '0;
      width       <= '0;
      height      <= '0;
      size_valid  <= 1'b0;
      error_count <= '0;
    end else begin
      size_valid <= commit;
      if (latch_len) len_q <= acc;
      if (latch_wid) wid_q <= acc;
      if (commit) begin
        length <= len_q;
        width  <= wid_q;
        height <= acc;
      end
      if (err_inc && (error_count != {ERROR_COUNT_WIDTH{1'b1}}))
        error_count <= error_count + ERROR_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dimension_parser.sv
// Bench for dimension_parser: line-level reference model plus directed and random byte streams.
module tb_dimension_parser;
  import dimension_parser_pkg::*;

  localparam int unsigned SW      = 8;
  localparam int unsigned EW      = 16;
  localparam int unsigned EW_SAT  = 2;
  localparam int          MAX_VAL = (1 << SW) - 1;
  localparam int          SAT_MAX = (1 << EW_SAT) - 1;

  typedef logic [7:0] char_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              inbound_valid;
  logic [7:0]        inbound_data;
  logic              size_valid, size_valid_s;
  size_t             length, width, height;
  logic [SW-1:0]     length_s, width_s, height_s;
  logic [EW-1:0]     error_count;
  logic [EW_SAT-1:0] error_count_s;

  int checks   = 0;
  int failures = 0;

  char_t line_q[$];
  bit    exp_valid;
  int    exp_len, exp_wid, exp_hgt, exp_err, exp_err_sat, exp_strobes;

  always #5 clk = ~clk;

  dimension_parser #(.SIZE_WIDTH(SW), .ERROR_COUNT_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .inbound_valid(inbound_valid), .inbound_data(inbound_data),
    .size_valid(size_valid), .length(length), .width(width), .height(height),
    .error_count(error_count)
  );

  dimension_parser #(.SIZE_WIDTH(SW), .ERROR_COUNT_WIDTH(EW_SAT)) dut_sat (
    .clk(clk), .rst(rst), .inbound_valid(inbound_valid), .inbound_data(inbound_data),
    .size_valid(size_valid_s), .length(length_s), .width(width_s), .height(height_s),
    .error_count(error_count_s)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Judges a whole line (CRs already removed): exactly three non-empty decimal fields, each <= MAX_VAL.
  function automatic void judge_line(input char_t q[$], output bit ok, output bit bad,
                                     output int f0, output int f1, output int f2);
    int f[3];
    int n   = 0;
    int cur = 0;
    bit seen = 0;
    ok = 0; bad = 0; f0 = 0; f1 = 0; f2 = 0;
    f[0] = 0; f[1] = 0; f[2] = 0;
    if (q.size() == 0) return;
    foreach (q[i]) begin
      if (bad) break;
      if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
        cur  = cur * 10 + int'(q[i] - 8'h30);
        seen = 1;
        if (cur > MAX_VAL) bad = 1;
      end else if (q[i] == 8'h78) begin
        if (!seen || n >= 2) bad = 1;
        else begin f[n] = cur; n++; cur = 0; seen = 0; end
      end else begin
        bad = 1;
      end
    end
    if (!bad && n == 2 && seen) begin
      ok = 1; f0 = f[0]; f1 = f[1]; f2 = cur;
    end else begin
      bad = 1;
    end
  endfunction

  // Reference model advanced on each edge, then every output compared just after it.
  always @(posedge clk) begin
    bit ok, bad;
    int a, b, c;
    if (rst) begin
      line_q.delete();
      exp_valid = 0; exp_len = 0; exp_wid = 0; exp_hgt = 0;
      exp_err = 0; exp_err_sat = 0;
    end else begin
      exp_valid = 0;
      if (inbound_valid) begin
        if (inbound_data == ASCII_LF) begin
          judge_line(line_q, ok, bad, a, b, c);
          if (ok) begin
            exp_valid = 1; exp_len = a; exp_wid = b; exp_hgt = c; exp_strobes++;
          end else if (bad) begin
            if (exp_err < (1 << EW) - 1) exp_err++;
            if (exp_err_sat < SAT_MAX) exp_err_sat++;
          end
          line_q.delete();
        end else if (inbound_data != ASCII_CR) begin
          line_q.push_back(inbound_data);
        end
      end
    end
    #1;
    check("size_valid", int'(size_valid), int'(exp_valid));
    check("length", int'(length), exp_len);
    check("width", int'(width), exp_wid);
    check("height", int'(height), exp_hgt);
    check("error_count", int'(error_count), exp_err);
    check("sat_size_valid", int'(size_valid_s), int'(exp_valid));
    check("sat_error_count", int'(error_count_s), exp_err_sat);
  end

  task automatic cycle(input bit v, input char_t d);
    @(negedge clk);
    inbound_valid = v;
    inbound_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic send(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      cycle(1'b1, s[i]);
    end
  endtask

  // Reset is held for one edge together with a valid byte, which must be dropped.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inbound_valid = 1'b1; inbound_data = 8'h35;
    @(negedge clk);
    rst = 1'b0; inbound_valid = 1'b0; inbound_data = 8'h00;
  endtask

  task automatic expect_fields(input string tag, input int l, input int w, input int h, input int e);
    check({tag, "_length"}, int'(length), l);
    check({tag, "_width"}, int'(width), w);
    check({tag, "_height"}, int'(height), h);
    check({tag, "_error_count"}, int'(error_count), e);
    check({tag, "_model_err"}, exp_err, e);
  endtask

  function automatic int rand_field();
    if ($urandom_range(0, 9) == 0) return $urandom_range(256, 999);
    return $urandom_range(0, 255);
  endfunction

  initial begin
    int    s0;
    string s;
    string cs;
    rst = 1'b1; inbound_valid = 1'b0; inbound_data = 8'h00;
    exp_strobes = 0;
    cs = "0123456789xx\rA ";
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_fields("reset", 0, 0, 0, 0);
    check("reset_size_valid", int'(size_valid), 0);

    s0 = exp_strobes;
    send("2x3x4\n", 3);
    idle(3);
    expect_fields("gapped", 2, 3, 4, 0);
    check("gapped_strobes", exp_strobes - s0, 1);

    s0 = exp_strobes;
    send("1x1x10\n29x13x26\n", 0);
    idle(2);
    expect_fields("b2b", 29, 13, 26, 0);
    check("b2b_strobes", exp_strobes - s0, 2);

    do_reset();
    s0 = exp_strobes;
    send("256x1x1\n5x5x5\n", 0);
    idle(2);
    expect_fields("overflow", 5, 5, 5, 1);
    check("overflow_strobes", exp_strobes - s0, 1);

    do_reset();
    s0 = exp_strobes;
    send("2x3\nx4x5\n7xAx2\n\r\n3x3x3\r\n", 1);
    idle(2);
    expect_fields("malformed", 3, 3, 3, 3);
    check("malformed_strobes", exp_strobes - s0, 1);

    send("12x3", 0);
    do_reset();
    expect_fields("midreset", 0, 0, 0, 0);
    check("midreset_size_valid", int'(size_valid), 0);
    s0 = exp_strobes;
    send("4x5x6\n", 0);
    idle(2);
    expect_fields("after_reset", 4, 5, 6, 0);
    check("after_reset_strobes", exp_strobes - s0, 1);

    do_reset();
    repeat (5) send("ab\n", 0);
    idle(2);
    check("sat_count", int'(error_count_s), 3);
    check("sat_model", exp_err_sat, 3);
    check("unsat_count", int'(error_count), 5);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 9) < 7) begin
        s = $sformatf("%0dx%0dx%0d", rand_field(), rand_field(), rand_field());
        if ($urandom_range(0, 4) == 0) s = {s, "\r"};
      end else begin
        s = "";
        for (int k = 0, len = $urandom_range(0, 8); k < len; k++)
          s = $sformatf("%s%c", s, cs[$urandom_range(0, cs.len() - 1)]);
      end
      if ($urandom_range(0, 19) != 0) s = {s, "\n"};
      send(s, ($urandom_range(0, 9) < 3) ? 0 : 2);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
